// File: rtl/adc_avg_seq.sv
// Sequences a reset-started ADC through 2^AVG_LOG2 conversions and emits their truncated mean.
// avg_vld pulses one cycle after the last capture; start is ignored while busy (no queueing).
module adc_avg_seq #(
  parameter int AVG_LOG2 = 3,
  parameter int GAP_CYC  = 16,
  parameter int TMO_CYC  = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        adc_fin,
  input  logic [11:0] adc_dout,
  output logic        adc_rst,
  output logic [11:0] avg_out,
  output logic        avg_vld,
  output logic        busy,
  output logic        tmo_err
);

  localparam int         ACC_W    = 12 + AVG_LOG2;
  localparam logic [4:0] LAST_IDX = 5'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    CAPT,
    GAP,
    DONE
  } state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [7:0]       tmo_cnt;
  logic [7:0]       gap_cnt;
  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
      acc     <= '0;
      adc_rst <= 1'b1;
      avg_out <= '0;
      avg_vld <= 1'b0;
      busy    <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CONV;
            adc_rst <= 1'b0;
            busy    <= 1'b1;
            tmo_err <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            tmo_cnt <= '0;
          end
        end
        CONV: begin
          // fin takes priority over the timeout on the last allowed cycle
          if (adc_fin) begin
            state   <= CAPT;
            adc_rst <= 1'b1;
          end else if (tmo_cnt == 8'(TMO_CYC - 1)) begin
            state   <= IDLE;
            adc_rst <= 1'b1;
            busy    <= 1'b0;
            tmo_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        CAPT: begin
          acc <= acc + ACC_W'(adc_dout);
          if (cnt == LAST_IDX) begin
            state <= DONE;
          end else begin
            cnt     <= cnt + 5'd1;
            gap_cnt <= '0;
            // the CAPT cycle is the first of the GAP_CYC held-in-reset cycles
            if (GAP_CYC == 1) begin
              state   <= CONV;
              adc_rst <= 1'b0;
              tmo_cnt <= '0;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYC - 2)) begin
            state   <= CONV;
            adc_rst <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        DONE: begin
          avg_out <= acc[AVG_LOG2 +: 12];
          avg_vld <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          adc_rst <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_avg_seq.sv
// Bench for adc_avg_seq: three instances (AVG_LOG2 = 3, 4, 0) each driven by a converter stub.
module tb_adc_avg_seq;

  localparam int GAP = 16;
  localparam int TMO = 200;

  typedef struct {
    logic [11:0] base;
    logic [11:0] step;
    int          lat;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [3];
  logic        fin   [3];
  logic [11:0] dout  [3];
  logic        arst  [3];
  logic [11:0] avg   [3];
  logic        vld   [3];
  logic        busy  [3];
  logic        terr  [3];

  always #20 clk = ~clk;

  adc_avg_seq u0 (
    .clk(clk), .rst(rst), .start(start[0]), .adc_fin(fin[0]), .adc_dout(dout[0]),
    .adc_rst(arst[0]), .avg_out(avg[0]), .avg_vld(vld[0]), .busy(busy[0]), .tmo_err(terr[0])
  );
  adc_avg_seq #(.AVG_LOG2(4)) u4 (
    .clk(clk), .rst(rst), .start(start[1]), .adc_fin(fin[1]), .adc_dout(dout[1]),
    .adc_rst(arst[1]), .avg_out(avg[1]), .avg_vld(vld[1]), .busy(busy[1]), .tmo_err(terr[1])
  );
  adc_avg_seq #(.AVG_LOG2(0)) u1 (
    .clk(clk), .rst(rst), .start(start[2]), .adc_fin(fin[2]), .adc_dout(dout[2]),
    .adc_rst(arst[2]), .avg_out(avg[2]), .avg_vld(vld[2]), .busy(busy[2]), .tmo_err(terr[2])
  );

  // Converter stub: fin rises lat cycles after reset release, holds until reset returns
  int          lat  [3];
  bit          hang [3];
  logic [11:0] smp  [3][16];
  int          scnt [3];
  int          sidx [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (arst[i]) begin
        fin[i]  <= 1'b0;
        scnt[i] <= 0;
      end else if (!fin[i] && !hang[i]) begin
        if (scnt[i] >= lat[i] - 1) begin
          fin[i]  <= 1'b1;
          dout[i] <= smp[i][sidx[i] & 15];
          sidx[i] <= sidx[i] + 1;
        end else begin
          scnt[i] <= scnt[i] + 1;
        end
      end
      if (!busy[i]) sidx[i] <= 0;
    end
  end

  int   n_cmp, n_bad;
  int   vld_cnt [3];
  int   win_cnt [3];
  int   hr      [3];
  int   lo_run  [3];
  int   last_lo [3];
  int   gmin    [3];
  int   gmax    [3];
  bit   seen_low [3];
  logic prev_arst [3];
  vec_t tbl [6];
  int   n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle and observe all instances at the falling edge
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) vld_cnt[i]++;
      if (!arst[i]) begin
        if (prev_arst[i]) begin
          win_cnt[i]++;
          if (seen_low[i]) begin
            if (hr[i] < gmin[i]) gmin[i] = hr[i];
            if (hr[i] > gmax[i]) gmax[i] = hr[i];
          end
          seen_low[i] = 1'b1;
          lo_run[i]   = 0;
        end
        lo_run[i]++;
        hr[i] = 0;
      end else begin
        if (!prev_arst[i]) last_lo[i] = lo_run[i];
        hr[i]++;
      end
      prev_arst[i] = arst[i];
    end
  endtask

  task automatic clr(input int i);
    vld_cnt[i]  = 0;
    win_cnt[i]  = 0;
    hr[i]       = 0;
    lo_run[i]   = 0;
    last_lo[i]  = 0;
    gmin[i]     = 100000;
    gmax[i]     = 0;
    seen_low[i] = 1'b0;
  endtask

  task automatic load_ramp(input int i, input logic [11:0] base, input logic [11:0] step);
    for (int k = 0; k < 16; k++) smp[i][k] = base + 12'(k) * step;
  endtask

  function automatic logic [11:0] model_avg(input int i, input int nsamp);
    int sum = 0;
    for (int k = 0; k < nsamp; k++) sum += int'(smp[i][k]);
    return 12'(sum / nsamp);
  endfunction

  task automatic finish_burst(input int i, input logic [11:0] exp, input int nwin,
                              input bit spam, input string name);
    int c = 0;
    while (busy[i] === 1'b1 && c < 6000) begin
      start[i] = (spam && (c % 37 == 5)) ? 1'b1 : 1'b0;
      tick();
      c++;
    end
    start[i] = 1'b0;
    chk({name, "_done"}, 32'(c < 6000), 1);
    repeat (3) tick();
    chk({name, "_avg"}, avg[i], exp);
    chk({name, "_vld_pulses"}, vld_cnt[i], 1);
    chk({name, "_windows"}, win_cnt[i], nwin);
    if (nwin > 1) begin
      chk({name, "_gap_min"}, gmin[i], GAP);
      chk({name, "_gap_max"}, gmax[i], GAP);
    end
    chk({name, "_tmo_err"}, terr[i], 0);
  endtask

  task automatic run_burst(input int i, input logic [11:0] exp, input int nwin,
                           input bit spam, input string name);
    clr(i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    finish_burst(i, exp, nwin, spam, name);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i]     = 1'b0;
      hang[i]      = 1'b0;
      lat[i]       = 70;
      prev_arst[i] = 1'b1;
      clr(i);
    end
    tbl[0] = '{12'h100, 12'h100, 70,  12'h480};
    tbl[1] = '{12'hFFF, 12'h000, 5,   12'hFFF};
    tbl[2] = '{12'h000, 12'h000, 1,   12'h000};
    tbl[3] = '{12'h001, 12'h001, 199, 12'h004};
    tbl[4] = '{12'h010, 12'h001, 20,  12'h013};
    tbl[5] = '{12'h7FF, 12'h001, 2,   12'h802};

    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_adc_rst%0d", i), arst[i], 1);
      chk($sformatf("reset_avg%0d", i), avg[i], 0);
      chk($sformatf("reset_vld%0d", i), vld[i], 0);
      chk($sformatf("reset_busy%0d", i), busy[i], 0);
      chk($sformatf("reset_tmo%0d", i), terr[i], 0);
    end

    // start presented on the very first edge after release
    load_ramp(0, 12'h100, 12'h100);
    rst      = 1'b0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("release_busy", busy[0], 1);
    chk("release_adc_rst", arst[0], 0);
    finish_burst(0, 12'h480, 8, 1'b0, "release_ramp");

    for (int v = 0; v < 6; v++) begin
      lat[0] = tbl[v].lat;
      load_ramp(0, tbl[v].base, tbl[v].step);
      run_burst(0, tbl[v].exp, 8, 1'b0, $sformatf("vec%0d", v));
    end

    // Timeout, with a start landing on the timeout edge
    hang[0] = 1'b1;
    clr(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (lo_run[0] < TMO && arst[0] === 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("tmo_busy", busy[0], 0);
    chk("tmo_err_set", terr[0], 1);
    chk("tmo_adc_rst", arst[0], 1);
    chk("tmo_low_len", last_lo[0], TMO);
    repeat (3) tick();
    chk("tmo_start_ignored", busy[0], 0);
    chk("tmo_no_vld", vld_cnt[0], 0);
    chk("tmo_avg_kept", avg[0], 12'h802);
    chk("tmo_err_sticky", terr[0], 1);

    hang[0] = 1'b0;
    lat[0]  = 30;
    load_ramp(0, 12'h200, 12'h000);
    clr(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("tmo_cleared", terr[0], 0);
    finish_burst(0, 12'h200, 8, 1'b0, "post_tmo");

    lat[0] = 70;
    load_ramp(0, 12'h100, 12'h100);
    run_burst(0, 12'h480, 8, 1'b1, "start_spam");

    // Reset in the 4th gap
    lat[0] = 40;
    load_ramp(0, 12'h050, 12'h010);
    clr(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (!(win_cnt[0] == 4 && arst[0] === 1'b1) && n < 3000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chk("mid_in_gap", arst[0], 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_adc_rst", arst[0], 1);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_avg", avg[0], 0);
    chk("mid_rst_vld", vld[0], 0);
    chk("mid_rst_no_vld", vld_cnt[0], 0);
    tick();
    rst = 1'b0;
    lat[0] = 15;
    load_ramp(0, 12'h123, 12'h000);
    run_burst(0, 12'h123, 8, 1'b0, "after_rst");

    for (int r = 0; r < 5; r++) begin
      lat[0] = $urandom_range(150, 1);
      for (int k = 0; k < 8; k++) smp[0][k] = 12'($urandom_range(4095, 0));
      run_burst(0, model_avg(0, 8), 8, 1'b0, $sformatf("rnd8_%0d", r));
    end

    lat[1] = 3;
    load_ramp(1, 12'hFFF, 12'h000);
    run_burst(1, 12'hFFF, 16, 1'b0, "l4_all_fff");
    for (int r = 0; r < 2; r++) begin
      lat[1] = $urandom_range(60, 1);
      for (int k = 0; k < 16; k++) smp[1][k] = 12'($urandom_range(4095, 0));
      run_burst(1, model_avg(1, 16), 16, 1'b0, $sformatf("rnd16_%0d", r));
    end

    lat[2] = 10;
    smp[2][0] = 12'hABC;
    run_burst(2, 12'hABC, 1, 1'b0, "l0_abc");
    for (int r = 0; r < 2; r++) begin
      lat[2] = $urandom_range(100, 1);
      smp[2][0] = 12'($urandom_range(4095, 0));
      run_burst(2, model_avg(2, 1), 1, 1'b0, $sformatf("rnd1_%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_avg_seq.md
ADC_AVG_SEQ -- requirements
Module: adc_avg_seq

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 3, meaning log2 of samples averaged per burst (legal 0..4).
REQ-002 SHALL have parameter GAP_CYC, default 16, meaning idle cycles with converter held in reset between conversions (legal 1..255).
REQ-003 SHALL have parameter TMO_CYC, default 200, meaning cycles allowed for converter fin before abort (legal 2..255).
REQ-004 SHALL have port clk  input  1  clock, 25 MHz, positive edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request for one averaged burst.
REQ-007 SHALL have port adc_fin  input  1  converter done flag, high until converter reset.
REQ-008 SHALL have port adc_dout  input  12  converter sample, stable while adc_fin high.
REQ-009 SHALL have port adc_rst  output  1  drives converter reset; high holds it idle, falling edge starts a conversion.
REQ-010 SHALL have port avg_out  output  12  averaged result.
REQ-011 SHALL have port avg_vld  output  1  one-cycle pulse, avg_out newly valid.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port tmo_err  output  1  sticky timeout flag.

Function
REQ-014 SHALL implement FSM states IDLE, CONV, CAPT, GAP, DONE; all outputs registered.
REQ-015 IDLE: adc_rst=1; start=1 -> CONV, clear sample count, accumulator and tmo_err.
REQ-016 CONV: adc_rst=0; timeout counter increments each cycle; adc_fin=1 -> CAPT; counter reaching TMO_CYC without fin -> IDLE, tmo_err=1, no avg_vld.
REQ-017 CAPT (1 cycle): accumulator += adc_dout (zero-extended); adc_rst=1; if sample count == 2^AVG_LOG2-1 -> DONE else count+1 -> GAP.
REQ-018 GAP: adc_rst=1 for exactly GAP_CYC cycles, then -> CONV with timeout counter cleared.
REQ-019 DONE (1 cycle): avg_out <= accumulator >> AVG_LOG2 (truncate, no rounding); avg_vld=1 on the next cycle for one cycle; -> IDLE.
REQ-020 Accumulator SHALL be 12+AVG_LOG2 bits wide; no overflow possible (all-0xFFF samples give avg 0xFFF).
REQ-021 AVG_LOG2=0: single sample, avg_out equals sample exactly.
REQ-022 start while busy=1 SHALL be ignored (no queueing, no restart).
REQ-023 adc_fin SHALL be ignored outside CONV.
REQ-024 start and timeout in the same cycle: timeout wins, FSM returns to IDLE; the start is ignored.
REQ-025 avg_out SHALL hold its value until the next DONE; unchanged on timeout abort.
REQ-026 tmo_err SHALL stay high until the next accepted start or rst.

Reset
REQ-027 rst SHALL force IDLE, adc_rst=1, avg_out=0, avg_vld=0, busy=0, tmo_err=0, all counters and accumulator 0.
REQ-028 rst mid-burst SHALL discard partial accumulation; no avg_vld emitted.
REQ-029 First start after rst release SHALL be accepted on the first clk edge where rst is low.

Verification
REQ-030 Converter stub returns 0x100,0x200,...,0x800 (fin 70 cycles after adc_rst falls), defaults -> avg_out=0x480, avg_vld single pulse, 8 adc_rst low windows each separated by 16 high cycles.
REQ-031 All samples 0xFFF, AVG_LOG2=4 -> avg_out=0xFFF, no wrap.
REQ-032 Stub never asserts fin -> adc_rst returns high after 200 CONV cycles, tmo_err=1, avg_vld never pulses, avg_out unchanged; next start clears tmo_err.
REQ-033 start pulsed repeatedly during burst -> exactly one avg_vld, burst length unchanged.
REQ-034 rst asserted during 4th GAP -> immediate adc_rst=1, busy=0, avg_out=0; new start yields correct fresh average.
REQ-035 AVG_LOG2=0, sample 0xABC -> avg_out=0xABC after one conversion.
